audio_ramp_feeder: RTL and testbench
====================================

# audio_ramp_feeder

Upstream feeder for the sigma-delta audio DAC. It accepts signed PCM samples from the sound sources over a valid/ready handshake and buffers them in a small FIFO. It releases one sample per fixed sample period, linearly interpolates between consecutive samples at clock rate, and drives the DAC's unsigned offset-binary input every clock. On underrun it holds the last sample and flags the event.

## Interface
- MSBI, 7: highest sample bit; samples and DAC word are MSBI+1 bits wide
- DEPTH_LOG2, 2: FIFO depth = 2^DEPTH_LOG2 entries
- RATE_LOG2, 8: sample period = 2^RATE_LOG2 CLK cycles
- CLK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- SAMPLE_IN  in  MSBI+1  signed two's-complement sample
- SAMPLE_VALID  in  1  SAMPLE_IN valid this cycle
- SAMPLE_READY  out  1  FIFO can accept; combinational = !RESET && level != 2^DEPTH_LOG2
- DACin  out  MSBI+1  registered unsigned offset-binary word to the DAC
- UNDERRUN  out  1  one-cycle pulse: boundary reached with FIFO empty
- LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy

## Operation
- Push: on a cycle with SAMPLE_VALID && SAMPLE_READY, write SAMPLE_IN at the tail.
- Phase counter: RATE_LOG2 bits, free-running, wraps. The boundary is the edge where phase == 2^RATE_LOG2-1.
- State registers:
  - cur, nxt: signed, MSBI+1 bits.
  - acc: signed, MSBI+2+RATE_LOG2 bits.
  - delta = nxt - cur: signed, MSBI+2 bits, no overflow.
- Non-boundary edge: phase++; acc <= acc + delta.
- Boundary edge:
  - phase <= 0; acc <= 0; cur <= nxt.
  - FIFO non-empty: nxt <= head and pop.
  - FIFO empty: nxt <= nxt (hold) and UNDERRUN <= 1 for exactly this next cycle.
- Interpolated value: y = cur + (acc >>> RATE_LOG2), computed at MSBI+2 bits with arithmetic shift (floor toward −inf). y always lies between cur and nxt, so it truncates to MSBI+1 bits without loss.
- DACin <= y[MSBI:0] with bit MSBI inverted (signed-to-offset-binary).
- Simultaneous push and pop: both take effect and LEVEL is unchanged. READY is evaluated from pre-edge level, so a full FIFO refuses a push even on a pop cycle.
- Full: SAMPLE_READY=0 and the input is ignored. Empty at boundary: hold, as above. Pointers wrap modulo depth.
- Reset (any time, including mid-ramp):
  - phase=0, cur=nxt=0, acc=0, FIFO empty (LEVEL=0).
  - UNDERRUN=0, DACin = 1<<MSBI (midscale, 0x80 for MSBI=7), SAMPLE_READY=0 while RESET high.
  - Samples in the FIFO are discarded.

## Timing
- SAMPLE_READY/LEVEL: READY is combinational from level. LEVEL updates the edge after a push or pop.
- DACin latency: one cycle behind the cur/acc registers.
- A sample pushed into an empty FIFO becomes nxt at the next boundary and cur one period later. DACin reaches it exactly at that later boundary +1 cycle; the ramp toward it spans the intervening period.
- First boundary after reset release: the 2^RATE_LOG2-th rising edge.
- UNDERRUN is high the cycle after the offending boundary edge, low otherwise.

## Structure
- Shared package audio_pkg:
  - midscale constant.
  - signed-to-offset-binary conversion function.
  - width helpers (MSBI+1, MSBI+2+RATE_LOG2).
- Sub-module audio_sample_fifo:
  - synchronous FIFO with push/pop/full/empty/level, parameterised by width and DEPTH_LOG2.
- Top holds the phase counter, cur/nxt/acc and output register.

## Test plan
Bench parameters: MSBI=7, RATE_LOG2=2, DEPTH_LOG2=2.
- Reset: assert RESET 3 cycles → DACin=0x80, UNDERRUN=0, LEVEL=0, SAMPLE_READY=0. After release, READY=1.
- Ramp: cur=0, push 64 → once 64 is nxt, DACin steps 0x80, 0x90, 0xA0, 0xB0, then 0xC0 after the next boundary.
- Extremes: push −128 then 127 → ramp monotonic, DACin stays within 0x00..0xFF, no wrap glitch.
- Backpressure: push 5 samples without boundary → 4 accepted, READY=0, LEVEL=4; 5th held by source and accepted after the next pop.
- Underrun: let FIFO drain → UNDERRUN pulses once per empty boundary, DACin holds last sample value.
- Mid-ramp reset: assert RESET at phase 2 with LEVEL=3 → next cycle DACin=0x80, LEVEL=0, phase restarts at 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the sigma-delta DAC feed path:
// midscale word, signed-to-offset-binary conversion and width helpers.
package audio_pkg;

   localparam int DEF_MSBI = 7;
   localparam logic [DEF_MSBI:0] MIDSCALE = 8'h80;

   function automatic int sample_w(input int msbi);
      return msbi + 1;
   endfunction

   function automatic int acc_w(input int msbi, input int rate_log2);
      return msbi + 2 + rate_log2;
   endfunction

   function automatic logic [31:0] midscale(input int msbi);
      return 32'd1 << msbi;
   endfunction

   // Two's complement to offset binary is a flip of the sign bit.
   function automatic logic [31:0] to_offset_binary(input logic [31:0] s, input int msbi);
      return s ^ (32'd1 << msbi);
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO holding PCM samples between the sources and the
// sample-rate release point. Read data is the head entry, valid when !empty.
module audio_sample_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/audio_ramp_feeder.sv
// Feeds the sigma-delta DAC: buffers signed PCM, releases one sample per
// 2^RATE_LOG2 clocks and linearly interpolates between consecutive samples.
module audio_ramp_feeder
   import audio_pkg::*;
#(
   parameter int MSBI       = 7,
   parameter int DEPTH_LOG2 = 2,
   parameter int RATE_LOG2  = 8
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic signed [MSBI:0]    SAMPLE_IN,
   input  logic                    SAMPLE_VALID,
   output logic                    SAMPLE_READY,
   output logic        [MSBI:0]    DACin,
   output logic                    UNDERRUN,
   output logic [DEPTH_LOG2:0]     LEVEL
);

   localparam int SW = sample_w(MSBI);
   localparam int DW = SW + 1;
   localparam int AW = acc_w(MSBI, RATE_LOG2);

   logic [RATE_LOG2-1:0]   phase_p0;
   logic signed [MSBI:0]   cur_p0;
   logic signed [MSBI:0]   nxt_p0;
   logic signed [AW-1:0]   acc_p0;
   logic signed [DW-1:0]   delta_p0;
   logic signed [DW-1:0]   y_p0;
   logic                   boundary;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic [MSBI:0]          head;

   // acc holds phase*delta, so acc/2^RATE_LOG2 never exceeds |delta| and y
   // stays between cur and nxt; the narrowing cast below is lossless.
   function automatic logic signed [DW-1:0] ramp_point(
      input logic signed [MSBI:0] cur,
      input logic signed [AW-1:0] acc
   );
      return DW'(cur) + DW'(acc >>> RATE_LOG2);
   endfunction

   audio_sample_fifo #(
      .WIDTH      (SW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (push),
      .pop   (pop),
      .wdata (SAMPLE_IN),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (LEVEL)
   );

   assign boundary     = (phase_p0 == '1);
   assign SAMPLE_READY = !RESET && !full;
   assign push         = SAMPLE_VALID && SAMPLE_READY;
   assign pop          = boundary && !empty;
   assign delta_p0     = DW'(nxt_p0) - DW'(cur_p0);
   assign y_p0         = ramp_point(cur_p0, acc_p0);

   // Stage p0: phase counter, sample pair and ramp accumulator.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         phase_p0 <= '0;
         cur_p0   <= '0;
         nxt_p0   <= '0;
         acc_p0   <= '0;
         UNDERRUN <= 1'b0;
      end else if (boundary) begin
         phase_p0 <= '0;
         acc_p0   <= '0;
         cur_p0   <= nxt_p0;
         if (!empty)
            nxt_p0 <= head;
         UNDERRUN <= empty;
      end else begin
         phase_p0 <= phase_p0 + 1'b1;
         acc_p0   <= acc_p0 + AW'(delta_p0);
         UNDERRUN <= 1'b0;
      end
   end

   // Stage p1: registered offset-binary word toward the DAC.
   always_ff @(posedge CLK) begin
      if (RESET)
         DACin <= SW'(midscale(MSBI));
      else
         DACin <= SW'(to_offset_binary(32'(y_p0), MSBI));
   end

endmodule

// File: tb/tb_audio_ramp_feeder.sv
// Bench for audio_ramp_feeder: per-cycle scoreboard against a reference model,
// hand-computed ramp table and directed backpressure/underrun/reset sequences.
module tb_audio_ramp_feeder;

   logic              CLK = 1'b0;
   logic              RESET;
   logic signed [7:0] SAMPLE_IN;
   logic              SAMPLE_VALID;
   logic              SAMPLE_READY;
   logic [7:0]        DACin;
   logic              UNDERRUN;
   logic [2:0]        LEVEL;

   audio_ramp_feeder #(
      .MSBI       (7),
      .DEPTH_LOG2 (2),
      .RATE_LOG2  (2)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .SAMPLE_IN    (SAMPLE_IN),
      .SAMPLE_VALID (SAMPLE_VALID),
      .SAMPLE_READY (SAMPLE_READY),
      .DACin        (DACin),
      .UNDERRUN     (UNDERRUN),
      .LEVEL        (LEVEL)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0] dac;
      logic       under;
      logic [2:0] level;
   } exp_t;

   typedef struct {
      logic signed [7:0] prev;
      logic signed [7:0] next;
      logic [7:0]        exp [5];
   } vec_t;

   exp_t   sb_q [$];
   int     m_fifo [$];
   int     m_phase, m_cur, m_nxt;
   int     errors = 0;
   int     checks = 0;
   vec_t   tbl [5];
   logic   took;
   int     idx, n, acc_c, pulses;
   logic signed [7:0] bp [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic cycle(input logic rst, input logic v, input logic signed [7:0] s, output logic tk);
      exp_t e;
      int   y;
      logic m_ready;
      RESET        = rst;
      SAMPLE_VALID = v;
      SAMPLE_IN    = s;
      #1;
      m_ready = !rst && (m_fifo.size() != 4);
      check("ready", 32'(SAMPLE_READY), 32'(m_ready));
      tk = v && SAMPLE_READY;
      if (rst) begin
         m_phase = 0; m_cur = 0; m_nxt = 0;
         m_fifo.delete();
         e.dac = 8'h80; e.under = 1'b0; e.level = 3'd0;
      end else begin
         y = m_cur + (((m_nxt - m_cur) * m_phase) >>> 2);
         e.dac = 8'((y + 128) & 255);
         if (m_phase == 3) begin
            e.under = (m_fifo.size() == 0);
            m_cur   = m_nxt;
            if (m_fifo.size() != 0)
               m_nxt = m_fifo.pop_front();
            m_phase = 0;
         end else begin
            e.under = 1'b0;
            m_phase++;
         end
         if (v && m_ready)
            m_fifo.push_back(int'(s));
         e.level = 3'(m_fifo.size());
      end
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      check("dacin", 32'(DACin), 32'(e.dac));
      check("underrun", 32'(UNDERRUN), 32'(e.under));
      check("level", 32'(LEVEL), 32'(e.level));
   endtask

   task automatic do_reset();
      logic t;
      repeat (3) cycle(1'b1, 1'b0, 8'sd0, t);
   endtask

   task automatic set_vec(input int i, input int p, input int nx, input logic [39:0] ev);
      tbl[i].prev = 8'(p);
      tbl[i].next = 8'(nx);
      for (int j = 0; j < 5; j++)
         tbl[i].exp[j] = ev[39-8*j -: 8];
   endtask

   initial begin
      RESET = 1'b1; SAMPLE_VALID = 1'b0; SAMPLE_IN = '0;
      set_vec(0,    0,   64, 40'h80_90_A0_B0_C0);
      set_vec(1, -128,  127, 40'h00_3F_7F_BF_FF);
      set_vec(2,  127, -128, 40'hFF_BF_7F_3F_00);
      set_vec(3,   10,    7, 40'h8A_89_88_87_87);
      set_vec(4,   -5,   -5, 40'h7B_7B_7B_7B_7B);
      bp[0] = 8'sd11; bp[1] = 8'sd22; bp[2] = 8'sd33;
      bp[3] = 8'sd44; bp[4] = 8'sd55; bp[5] = -8'sd66;

      // Reset state, then READY after release.
      do_reset();
      check("rst_dac", 32'(DACin), 32'h80);
      check("rst_under", 32'(UNDERRUN), 32'd0);
      check("rst_level", 32'(LEVEL), 32'd0);
      check("rst_ready", 32'(SAMPLE_READY), 32'd0);
      RESET = 1'b0;
      #1;
      check("ready_after_rst", 32'(SAMPLE_READY), 32'd1);

      // Ramp table: prev becomes cur at edge 8, ramp observed on edges 9..13.
      for (int i = 0; i < 5; i++) begin
         do_reset();
         cycle(1'b0, 1'b1, tbl[i].prev, took);
         cycle(1'b0, 1'b1, tbl[i].next, took);
         repeat (6) cycle(1'b0, 1'b0, 8'sd0, took);
         for (int j = 0; j < 5; j++) begin
            cycle(1'b0, 1'b0, 8'sd0, took);
            check($sformatf("tbl%0d_step%0d", i, j), 32'(DACin), 32'(tbl[i].exp[j]));
         end
      end

      // Underrun: empty FIFO, cur=nxt=-5; 16 cycles hold 4 boundaries.
      pulses = 0;
      for (int c = 0; c < 16; c++) begin
         cycle(1'b0, 1'b0, 8'sd0, took);
         if (UNDERRUN) pulses++;
         check("hold_dac", 32'(DACin), 32'h7B);
      end
      check("underrun_pulses", 32'(pulses), 32'd4);

      // Backpressure: six samples offered back to back, source holds when refused.
      do_reset();
      idx = 0; acc_c = -1;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         cycle(1'b0, 1'b1, bp[idx], took);
         if (took) begin
            idx++;
            if (idx == 6) acc_c = c;
         end
         if (c == 5) begin
            check("bp_accepted", 32'(idx), 32'd5);
            check("bp_level_full", 32'(LEVEL), 32'd4);
            check("bp_ready_low", 32'(SAMPLE_READY), 32'd0);
         end
      end
      check("bp_last_accept_cycle", 32'(acc_c), 32'd8);
      repeat (24) cycle(1'b0, 1'b0, 8'sd0, took);

      // Mid-ramp reset at phase 2 with three samples queued.
      do_reset();
      cycle(1'b0, 1'b1, 8'sd100, took);
      cycle(1'b0, 1'b1, -8'sd50, took);
      cycle(1'b0, 1'b1, 8'sd20, took);
      cycle(1'b0, 1'b0, 8'sd0, took);
      cycle(1'b0, 1'b1, 8'sd7, took);
      cycle(1'b0, 1'b0, 8'sd0, took);
      check("mid_level_before", 32'(LEVEL), 32'd3);
      cycle(1'b1, 1'b0, 8'sd0, took);
      check("mid_rst_dac", 32'(DACin), 32'h80);
      check("mid_rst_level", 32'(LEVEL), 32'd0);
      n = 0;
      do begin
         cycle(1'b0, 1'b0, 8'sd0, took);
         n++;
      end while (!UNDERRUN && n < 10);
      check("mid_first_boundary", 32'(n), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
